// File: rtl/fan_pwm_meter.sv
// fan_pwm_meter: measures period and high time of an incoming fan PWM line,
// converts the high time to an N-bit duty fraction with a sequential restoring
// divider and decodes the duty to the 8-level one-hot fan state.
// Optional build macro FAN_PWM_METER_AVG_EN: report the mean of the last four
// quotients instead of the raw quotient (one extra cycle of latency).
module fan_pwm_meter #(
    parameter int  SYS_FREQ = 125,
    parameter int  N        = 12,
    parameter int  MIN_FREQ = 50,
    localparam int TO       = (SYS_FREQ * 1000000) / MIN_FREQ,
    localparam int TW       = $clog2(TO + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pwm_in,
    output logic [N-1:0]  duty,
    output logic [TW-1:0] period,
    output logic [7:0]    level,
    output logic          valid,
    output logic          signal_lost,
    output logic          overrun
);

    localparam logic [TW-1:0] TO_V      = TW'(TO);
    localparam int            CW        = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam int            F         = (1 << N) / 16;

    typedef enum logic [1:0] {
        M_WAIT = 2'd0,
        M_HIGH = 2'd1,
        M_LOW  = 2'd2
    } m_state_t;

    // Duty-to-fan-state thresholds in units of F = 2^N/16.
    function automatic logic [7:0] decode_level(input logic [N-1:0] d);
        int dv;
        dv = int'(d);
        if (dv < 2 * F)       return 8'b0000_0001;
        else if (dv < 5 * F)  return 8'b0000_0010;
        else if (dv < 7 * F)  return 8'b0000_0100;
        else if (dv < 9 * F)  return 8'b0000_1000;
        else if (dv < 11 * F) return 8'b0001_0000;
        else if (dv < 13 * F) return 8'b0010_0000;
        else if (dv < 15 * F) return 8'b0100_0000;
        else                  return 8'b1000_0000;
    endfunction

    logic          sync1_q, sync2_q, prev_q;
    m_state_t      state_q, state_d;
    logic [TW-1:0] per_cnt_q, per_cnt_d;
    logic [TW-1:0] hi_cnt_q, hi_cnt_d;

    logic          div_busy_q, div_busy_d;
    logic          div_done_q, div_done_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [TW-1:0] div_rem_q, div_rem_d;
    logic [TW-1:0] div_den_q, div_den_d;
    logic [N-2:0]  div_quo_q, div_quo_d;

    logic [N-1:0]  duty_q, duty_d;
    logic [TW-1:0] period_q, period_d;
    logic [7:0]    level_q, level_d;
    logic          valid_q, valid_d;
    logic          lost_q, lost_d;

    logic          rise, fall, capture, timeout, div_active, accept;
    logic [TW-1:0] rem_shl, rem_step;
    logic          step_ge, div_last;
    logic [N-1:0]  quo_step;
    logic [N-1:0]  forced_duty;
    logic          res_load;
    logic [N-1:0]  res_duty;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise        = sync2_q & ~prev_q;
    assign fall        = ~sync2_q & prev_q;
    assign capture     = (state_q == M_LOW) && rise;
    // A capture in the same cycle suppresses the timeout.
    assign timeout     = (per_cnt_q == (TO_V - TW'(1))) && !rise;
    // The divider is considered occupied until its result cycle has passed.
    assign div_active  = div_busy_q | div_done_q;
    assign accept      = capture & ~div_active;
    assign overrun     = capture & div_active;
    assign forced_duty = {N{sync2_q}};

    // One restoring-division step: the dividend's low bits are all zero, so only zeros shift in.
    assign rem_shl  = {div_rem_q[TW-2:0], 1'b0};
    assign step_ge  = div_rem_q[TW-1] | (rem_shl >= div_den_q);
    assign rem_step = step_ge ? (rem_shl - div_den_q) : rem_shl;
    assign quo_step = {div_quo_q, step_ge};
    assign div_last = div_busy_q && (div_cnt_q == LAST_STEP);

    // Measurement FSM and the saturating period/high counters.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise) begin
            per_cnt_d = TW'(1);
        end else if (per_cnt_q != TO_V) begin
            per_cnt_d = per_cnt_q + TW'(1);
        end
        case (state_q)
            M_WAIT: begin
                if (rise) begin
                    state_d  = M_HIGH;
                    hi_cnt_d = TW'(1);
                end
            end
            M_HIGH: begin
                if (fall) begin
                    state_d = M_LOW;
                end else if (hi_cnt_q != TO_V) begin
                    hi_cnt_d = hi_cnt_q + TW'(1);
                end
            end
            M_LOW: begin
                if (rise) begin
                    state_d  = M_HIGH;
                    hi_cnt_d = TW'(1);
                end
            end
            default: state_d = M_WAIT;
        endcase
        if (timeout) begin
            state_d = M_WAIT;
        end
    end

    // Divider control: load on an accepted capture, N steps, abort on timeout.
    always_comb begin
        div_busy_d = div_busy_q;
        div_done_d = 1'b0;
        div_cnt_d  = div_cnt_q;
        div_rem_d  = div_rem_q;
        div_den_d  = div_den_q;
        div_quo_d  = div_quo_q;
        if (div_busy_q) begin
            div_cnt_d = div_cnt_q + CW'(1);
            div_rem_d = rem_step;
            div_quo_d = quo_step[N-2:0];
            if (div_last) begin
                div_busy_d = 1'b0;
                div_done_d = 1'b1;
            end
        end
        if (accept) begin
            div_busy_d = 1'b1;
            div_cnt_d  = '0;
            div_rem_d  = hi_cnt_q;
            div_den_d  = per_cnt_q;
            div_quo_d  = '0;
        end
        if (timeout) begin
            div_busy_d = 1'b0;
            div_done_d = 1'b0;
        end
    end

`ifdef FAN_PWM_METER_AVG_EN
    logic [N-1:0] win_q [4];
    logic [N-1:0] win_d [4];
    logic         fill_q, fill_d;
    logic [N+1:0] avg_sum;

    // Averaging window: first quotient after reset/loss fills all slots.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (div_last) begin
            if (fill_q) begin
                for (int i = 0; i < 4; i++) win_d[i] = quo_step;
                fill_d = 1'b0;
            end else begin
                for (int i = 3; i > 0; i--) win_d[i] = win_q[i-1];
                win_d[0] = quo_step;
            end
        end
        if (timeout) begin
            for (int i = 0; i < 4; i++) win_d[i] = forced_duty;
            fill_d = 1'b1;
        end
    end

    // Window storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
            fill_q <= 1'b1;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

    assign avg_sum  = {2'b00, win_q[0]} + {2'b00, win_q[1]} + {2'b00, win_q[2]} + {2'b00, win_q[3]};
    assign res_load = div_done_q;
    assign res_duty = N'(avg_sum >> 2);
`else
    assign res_load = div_last;
    assign res_duty = quo_step;
`endif

    // Output registers: a finished measurement updates them; a timeout overrides.
    always_comb begin
        duty_d   = duty_q;
        period_d = period_q;
        level_d  = level_q;
        valid_d  = 1'b0;
        lost_d   = lost_q;
        if (res_load) begin
            duty_d   = res_duty;
            level_d  = decode_level(res_duty);
            period_d = div_den_q;
            valid_d  = 1'b1;
            lost_d   = 1'b0;
        end
        if (timeout) begin
            duty_d   = forced_duty;
            level_d  = decode_level(forced_duty);
            period_d = TO_V;
            valid_d  = 1'b1;
            lost_d   = 1'b1;
        end
    end

    // State, divider and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= M_WAIT;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            div_busy_q <= 1'b0;
            div_done_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_den_q  <= '0;
            div_quo_q  <= '0;
            duty_q     <= '0;
            period_q   <= '0;
            level_q    <= 8'b0000_0001;
            valid_q    <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            div_busy_q <= div_busy_d;
            div_done_q <= div_done_d;
            div_cnt_q  <= div_cnt_d;
            div_rem_q  <= div_rem_d;
            div_den_q  <= div_den_d;
            div_quo_q  <= div_quo_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            lost_q     <= lost_d;
        end
    end

    assign duty        = duty_q;
    assign period      = period_q;
    assign level       = level_q;
    assign valid       = valid_q;
    assign signal_lost = lost_q;

endmodule

// File: tb/tb_fan_pwm_meter.sv
// Directed bench for fan_pwm_meter with a scaled clock (TO = 500 cycles).
module tb_fan_pwm_meter;

    localparam int NN  = 12;
    localparam int TOC = 500;
    localparam int TW  = $clog2(TOC + 1);
`ifdef FAN_PWM_METER_AVG_EN
    localparam int LAT = NN + 4;
`else
    localparam int LAT = NN + 3;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pwm_in = 1'b0;
    logic [NN-1:0] duty;
    logic [TW-1:0] period;
    logic [7:0]    level;
    logic          valid, signal_lost, overrun;

    int n_total = 0, n_pass = 0, n_fail = 0;
    int neg_n = 0, last_rise = 0;
    int vcount, ocount, lat, first_duty;
    logic [31:0] last_duty, last_level, last_period;

    fan_pwm_meter #(.SYS_FREQ(1), .N(NN), .MIN_FREQ(2000)) dut (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in), .duty(duty), .period(period),
        .level(level), .valid(valid), .signal_lost(signal_lost), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        vcount = 0; ocount = 0; lat = 0; first_duty = -1;
        last_duty = '0; last_level = '0; last_period = '0;
    endtask

    // Called at each negedge, before the stimulus for that negedge is applied.
    task automatic sample();
        neg_n++;
        if (valid) begin
            vcount++;
            if (vcount == 1) first_duty = int'(duty);
            last_duty = 32'(duty); last_level = 32'(level); last_period = 32'(period);
            lat = neg_n - last_rise;
            $display("valid @%0d: duty=%0d period=%0d level=%b lost=%0b", neg_n, duty, period, level, signal_lost);
        end
        if (overrun) ocount++;
    endtask

    task automatic drive(input int hi, input int per, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < per; i++) begin
                @(negedge clk);
                sample();
                pwm_in = (i < hi);
                if (i == 0) last_rise = neg_n;
            end
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample();
            pwm_in = v;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".duty"}, 32'(duty), 0);
        chk({tag, ".period"}, 32'(period), 0);
        chk({tag, ".level"}, 32'(level), 32'h01);
        chk({tag, ".valid"}, 32'(valid), 0);
        chk({tag, ".lost"}, 32'(signal_lost), 1);
        chk({tag, ".overrun"}, 32'(overrun), 0);
    endtask

    // One complete period after reset yields exactly one measurement.
    task automatic measure_one(input string tag, input int hi, input int per,
                               input int exp_duty, input int exp_level);
        do_reset();
        drive(hi, per, 2);
        chk({tag, ".vcount"}, 32'(vcount), 1);
        chk({tag, ".duty"}, last_duty, 32'(exp_duty));
        chk({tag, ".level"}, last_level, 32'(exp_level));
        chk({tag, ".period"}, last_period, 32'(per));
    endtask

    initial begin
        clear_stats();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_reset_values("rst0");

        // 75% run, then line held low until timeout
        do_reset();
        drive(150, 200, 2);
        chk("d75.duty", last_duty, 3072);
        chk("d75.level", last_level, 32'h20);
        clear_stats();
        hold(1'b0, 600);
        chk("lostlo.vcount", 32'(vcount), 1);
        chk("lostlo.duty", last_duty, 0);
        chk("lostlo.level", last_level, 32'h01);
        chk("lostlo.lost", 32'(signal_lost), 1);

        // 50% run from the lost state: lost clears, latency check
        clear_stats();
        drive(100, 200, 3);
        chk("d50.vcount", 32'(vcount), 2);
        chk("d50.duty", last_duty, 2048);
        chk("d50.period", last_period, 200);
        chk("d50.level", last_level, 32'h08);
        chk("d50.latency", 32'(lat), 32'(LAT));
        chk("d50.lost", 32'(signal_lost), 0);
        chk("d50.overrun", 32'(ocount), 0);

        // rising edge closes the 50% period, then line held high until timeout
        clear_stats();
        hold(1'b1, 600);
        chk("losthi.vcount", 32'(vcount), 2);
        chk("losthi.duty", last_duty, 4095);
        chk("losthi.level", last_level, 32'h80);
        chk("losthi.lost", 32'(signal_lost), 1);

        do_reset();
        check_reset_values("rst1");

        measure_one("d25", 50, 200, 1024, 32'h02);
        measure_one("floor", 70, 210, 1365, 32'h04);
        measure_one("th2F", 25, 200, 512, 32'h02);
        measure_one("below2F", 24, 200, 491, 32'h01);
        measure_one("th5F", 100, 320, 1280, 32'h04);
        measure_one("max", 199, 200, 4075, 32'h80);
        measure_one("min", 1, 200, 20, 32'h01);

        // period 10: every other capture hits a busy divider
        do_reset();
        drive(5, 10, 7);
        chk("ovr.count", 32'(ocount), 3);
        chk("ovr.vcount", 32'(vcount), 3);
        chk("ovr.duty", last_duty, 2048);
        chk("ovr.period", last_period, 10);

        // reset asserted while the divider is running
        do_reset();
        drive(100, 200, 2);
        chk("mid.pre_duty", last_duty, 2048);
        hold(1'b1, 6);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("mid");
        reset_n = 1'b1;
        clear_stats();
        hold(1'b1, 30);
        chk("mid.novalid", 32'(vcount), 0);

`ifdef FAN_PWM_METER_AVG_EN
        // alternating 25%/75% samples: first report is 1024, full window gives 2048
        do_reset();
        drive(50, 200, 1);
        drive(150, 200, 1);
        drive(50, 200, 1);
        drive(150, 200, 1);
        drive(50, 200, 1);
        drive(150, 200, 1);
        chk("avg.vcount", 32'(vcount), 5);
        chk("avg.first", 32'(first_duty), 1024);
        chk("avg.last", last_duty, 2048);
        chk("avg.level", last_level, 32'h08);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
